// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared definitions for the instruction fetch stage.
//   fetch_state_e    : fetch controller state encoding (2 bits)
//   NOP_INST_DEFAULT : addi x0,x0,0, shown on if_inst while nothing valid is held
//   OPC_HI / OPC_LO  : opcode field bounds inside an instruction word
//   PC_STEP          : sequential fetch increment in bytes
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_ISSUE   = 2'd0,
    FETCH_WAIT    = 2'd1,
    FETCH_HOLD    = 2'd2,
    FETCH_DISCARD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;
  localparam int          OPC_HI           = 6;
  localparam int          OPC_LO           = 2;
  localparam int unsigned PC_STEP          = 4;

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode.
// Keeps the PC, issues one instruction-memory request at a time, buffers the
// returned word (plus a one-entry skid when decode stalls) and presents
// {pc, inst, opcode} to decode under valid/ready. A redirect from execute
// flushes anything in flight or buffered.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req/addr/gnt        request channel (addr = pc_q, word aligned)
//   imem_rvalid/rdata        response channel
//   id_ready                 decode accepts if_* this cycle
//   if_valid/pc/inst/opcode  instruction presented to decode
//   redirect_valid/pc        taken branch/jump target from execute
//
// state         | meaning
// FETCH_ISSUE   | request pc_q, waiting for grant
// FETCH_WAIT    | request granted, waiting for response
// FETCH_HOLD    | response parked in skid, decode stalled
// FETCH_DISCARD | redirected while a response is pending, drop it on arrival
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = NOP_INST_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_inst,
  output logic [4:0]      if_opcode,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic            if_valid_q;
  logic [XLEN-1:0] if_pc_q;
  logic [31:0]     if_inst_q;
  logic [XLEN-1:0] skid_pc_q;
  logic [31:0]     skid_inst_q;

  logic            slot_free;
  logic [XLEN-1:0] redirect_pc_d;
  logic [XLEN-1:0] pc_next_d;

  assign slot_free     = !if_valid_q || id_ready;
  assign redirect_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
  assign pc_next_d     = pc_q + XLEN'(PC_STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH_ISSUE;
      pc_q        <= RESET_PC;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      if_inst_q   <= NOP_INST;
      skid_pc_q   <= '0;
      skid_inst_q <= NOP_INST;
    end else begin
      // A consumed slot empties unless a state below refills it.
      if (if_valid_q && id_ready) begin
        if_valid_q <= 1'b0;
        if_inst_q  <= NOP_INST;
      end
      case (state_q)
        FETCH_ISSUE: begin
          if (imem_gnt) state_q <= redirect_valid ? FETCH_DISCARD : FETCH_WAIT;
        end
        FETCH_WAIT: begin
          if (redirect_valid) begin
            // A response in the same cycle is simply dropped.
            state_q <= imem_rvalid ? FETCH_ISSUE : FETCH_DISCARD;
          end else if (imem_rvalid) begin
            pc_q <= pc_next_d;
            if (slot_free) begin
              if_valid_q <= 1'b1;
              if_pc_q    <= pc_q;
              if_inst_q  <= imem_rdata;
              state_q    <= FETCH_ISSUE;
            end else begin
              skid_pc_q   <= pc_q;
              skid_inst_q <= imem_rdata;
              state_q     <= FETCH_HOLD;
            end
          end
        end
        FETCH_HOLD: begin
          if (redirect_valid) begin
            state_q <= FETCH_ISSUE;
          end else if (id_ready) begin
            if_valid_q <= 1'b1;
            if_pc_q    <= skid_pc_q;
            if_inst_q  <= skid_inst_q;
            state_q    <= FETCH_ISSUE;
          end
        end
        FETCH_DISCARD: begin
          if (imem_rvalid) state_q <= FETCH_ISSUE;
        end
        default: state_q <= FETCH_ISSUE;
      endcase
      // Redirect overrides any load or skid transfer above.
      if (redirect_valid) begin
        pc_q       <= redirect_pc_d;
        if_valid_q <= 1'b0;
        if_inst_q  <= NOP_INST;
      end
    end
  end

  assign imem_req  = (state_q == FETCH_ISSUE) && !rst;
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;
  assign if_opcode = if_inst_q[OPC_HI:OPC_LO];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios followed by randomized traffic against a
// transaction-level model (expected fetch address and expected delivered PC
// streams plus a one-outstanding memory model).
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc, if_inst;
  logic [4:0]  if_opcode;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_pc, w_inst;
  logic [4:0]  w_opcode;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_ready(id_ready),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_opcode(if_opcode),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_ready(id_ready),
    .if_valid(w_valid), .if_pc(w_pc), .if_inst(w_inst), .if_opcode(w_opcode),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h00A0_0093;
      32'h8:   return 32'h0010_0113;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  // reference model state
  logic [31:0] exp_fetch = 32'h0;
  logic [31:0] exp_deliv = 32'h0;
  bit          pending = 0;
  int          lat = 0;
  logic [31:0] pend_addr = 32'h0;
  bit          stray = 0;
  int          lat_lo = 1, lat_hi = 1;
  bit          prev_rst = 1, prev_rdv = 0, prev_valid = 0, prev_rdy = 1;
  int          deliv_cnt = 0;
  int          gap = 0;

  // Drive one cycle of inputs just after a falling edge, check the outputs,
  // advance the model, and return at the next falling edge.
  task automatic step(input bit r, input bit g, input bit rdy, input bit rdv,
                      input logic [31:0] rpc);
    bit          resp;
    bit          grant;
    logic [31:0] tgt;
    rst = r; imem_gnt = g; id_ready = rdy; redirect_valid = rdv; redirect_pc = rpc;
    resp = !r && pending && (lat == 0);
    if (resp) begin
      imem_rvalid = 1'b1; imem_rdata = mem_word(pend_addr);
    end else if (stray && !r) begin
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; stray = 0;
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    #1;
    if (prev_rst) begin
      chk("post_rst_valid", {31'b0, if_valid}, 32'd0);
      chk("post_rst_inst", if_inst, NOP);
    end else if (prev_rdv) begin
      chk("flush_valid", {31'b0, if_valid}, 32'd0);
      chk("flush_inst", if_inst, NOP);
    end else if (prev_valid && !prev_rdy) begin
      chk("stall_valid", {31'b0, if_valid}, 32'd1);
    end
    if (if_valid) begin
      chk("if_pc", if_pc, exp_deliv);
      chk("if_inst", if_inst, mem_word(exp_deliv));
      chk("if_opcode", {27'b0, if_opcode}, {27'b0, mem_word(exp_deliv) >> 2} & 32'h1F);
    end else begin
      chk("idle_inst", if_inst, NOP);
      chk("idle_opcode", {27'b0, if_opcode}, 32'h04);
    end
    if (r) begin
      chk("req_in_rst", {31'b0, imem_req}, 32'd0);
    end else if (pending) begin
      chk("one_outstanding", {31'b0, imem_req}, 32'd0);
    end
    grant = !r && imem_req && g;
    if (grant) chk("fetch_addr", imem_addr, exp_fetch);
    prev_valid = if_valid; prev_rdy = rdy; prev_rdv = rdv; prev_rst = r;
    if (if_valid && rdy) begin
      exp_deliv += 32'd4;
      deliv_cnt++;
      gap = 0;
    end else begin
      gap++;
    end
    if (resp) pending = 0;
    else if (pending && lat > 0) lat--;
    if (grant) begin
      pending = 1; pend_addr = imem_addr; lat = $urandom_range(lat_hi, lat_lo) - 1;
    end
    tgt = {rpc[31:2], 2'b00};
    if (rdv) begin
      exp_fetch = tgt; exp_deliv = tgt;
    end else if (grant) begin
      exp_fetch += 32'd4;
    end
    if (r) begin
      exp_fetch = 32'h0; exp_deliv = 32'h0; pending = 0; gap = 0;
    end
    if (gap > 300) begin
      chk("deliv_gap", gap, 300);
      gap = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(negedge clk);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_addr_w", w_addr, 32'hFFFF_FFFC);

    // back-to-back fetch, one instruction every other cycle
    step(0, 1, 1, 0, 0);
    chk("lat_c1_valid", {31'b0, if_valid}, 32'd0);
    step(0, 1, 1, 0, 0);
    chk("lat_c2_valid", {31'b0, if_valid}, 32'd1);
    chk("lat_c2_pc", if_pc, 32'h0);
    chk("lat_c2_opc", {27'b0, if_opcode}, 32'h04);
    chk("wrap_req", {31'b0, w_req}, 32'd1);
    chk("wrap_addr", w_addr, 32'h0);
    chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
    step(0, 1, 1, 0, 0);
    chk("seq_c3_valid", {31'b0, if_valid}, 32'd0);
    step(0, 1, 1, 0, 0);
    chk("seq_c4_pc", if_pc, 32'h4);
    chk("seq_c4_inst", if_inst, 32'h00A0_0093);

    // decode stalls while the next response arrives
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 0);
      chk("stall_pc", if_pc, 32'h4);
      if (i > 0) chk("hold_no_req", {31'b0, imem_req}, 32'd0);
    end
    step(0, 1, 1, 0, 0);
    chk("skid_valid", {31'b0, if_valid}, 32'd1);
    chk("skid_pc", if_pc, 32'h8);
    chk("resume_req", {31'b0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, 32'hC);

    // redirect while waiting; the late response must be discarded
    lat_lo = 2; lat_hi = 2;
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 32'h100);
    chk("redir_valid", {31'b0, if_valid}, 32'd0);
    step(0, 1, 1, 0, 0);
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_req", {31'b0, imem_req}, 32'd1);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("redir_pc", if_pc, 32'h100);
    lat_lo = 1; lat_hi = 1;

    // redirect together with the response
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 32'h203);
    chk("same_cyc_valid", {31'b0, if_valid}, 32'd0);
    chk("same_cyc_addr", imem_addr, 32'h200);

    // reset while waiting, then a stray response
    step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    stray = 1;
    chk("rst_wait_inst", if_inst, NOP);
    step(0, 0, 1, 0, 0);
    chk("stray_valid", {31'b0, if_valid}, 32'd0);
    chk("stray_addr", imem_addr, 32'h0);
    chk("stray_req", {31'b0, imem_req}, 32'd1);

    // randomized traffic
    lat_lo = 1; lat_hi = 3;
    deliv_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rpc);
    end
    chk("deliv_count_ok", {31'b0, deliv_cnt >= 100}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
